// File: rtl/clock_pkg.sv
// Shared definitions for the desk-clock time-setting controller:
// state encoding, edit_field codes, field width, default limits and
// the wrap-around arithmetic used by every editable field.
package clock_pkg;

  localparam int FIELD_W      = 6;
  localparam int DEF_HOUR_MAX = 23;
  localparam int DEF_MIN_MAX  = 59;
  localparam int DEF_SEC_MAX  = 59;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EF_NONE = 2'd0,
    EF_HOUR = 2'd1,
    EF_MIN  = 2'd2,
    EF_SEC  = 2'd3
  } edit_field_e;

  // Increment with wrap to zero once the limit is reached (an out-of-range
  // snapshot also wraps to zero rather than running past the limit).
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] val,
                                                  input logic [FIELD_W-1:0] max);
    if (val >= max) begin
      wrap_inc = {FIELD_W{1'b0}};
    end else begin
      wrap_inc = val + {{(FIELD_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Decrement with wrap from zero back to the limit.
  function automatic logic [FIELD_W-1:0] wrap_dec(input logic [FIELD_W-1:0] val,
                                                  input logic [FIELD_W-1:0] max);
    if (val == {FIELD_W{1'b0}}) begin
      wrap_dec = max;
    end else begin
      wrap_dec = val - {{(FIELD_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/field_editor.sv
// One editable time field: snapshot load from the live counter, plus
// wrap-around increment/decrement while the field is selected.
module field_editor
  import clock_pkg::*;
#(
  parameter int MAX = DEF_MIN_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               snap_en_i,
  input  logic [FIELD_W-1:0] snap_val_i,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [FIELD_W-1:0] value_o
);

  localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX);

  logic [FIELD_W-1:0] value_q;
  logic [FIELD_W-1:0] value_d;

  // Next value: snapshot has priority; simultaneous inc and dec cancel out.
  always_comb begin
    value_d = value_q;
    if (snap_en_i) begin
      value_d = snap_val_i;
    end else if (en_i && inc_i && !dec_i) begin
      value_d = wrap_inc(value_q, MAX_V);
    end else if (en_i && dec_i && !inc_i) begin
      value_d = wrap_dec(value_q, MAX_V);
    end else begin
      value_d = value_q;
    end
  end

  // Field value register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= {FIELD_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: turns debounced button pulses into an
// hour -> minute -> second edit session, freezes timekeeping while editing,
// issues one load strobe on commit and drives field blanking for blinking.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOUR_MAX  = DEF_HOUR_MAX,
  parameter int MIN_MAX   = DEF_MIN_MAX,
  parameter int SEC_MAX   = DEF_SEC_MAX,
  parameter int TIMEOUT_S = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic               tick_1hz,
  input  logic               tick_blink,
  input  logic [FIELD_W-1:0] cur_hour,
  input  logic [FIELD_W-1:0] cur_min,
  input  logic [FIELD_W-1:0] cur_sec,
  output logic               run_en,
  output logic               load_en,
  output logic [FIELD_W-1:0] hour_data,
  output logic [FIELD_W-1:0] min_data,
  output logic [FIELD_W-1:0] sec_data,
  output logic [1:0]         edit_field,
  output logic [2:0]         field_visible
);

  // The timer only ever needs to hold 0..TIMEOUT_S-1.
  localparam int               TMR_W      = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_S - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             blink_q, blink_d;
  logic             run_en_q, run_en_d;
  logic             load_en_q, load_en_d;
  edit_field_e      edit_field_q, edit_field_d;
  logic [2:0]       field_visible_q, field_visible_d;

  logic in_edit_s;
  logic incdec_s;
  logic accepted_s;
  logic timeout_s;
  logic snap_s;

  assign in_edit_s  = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);
  assign incdec_s   = btn_inc ^ btn_dec;
  assign accepted_s = in_edit_s && (btn_mode || incdec_s);
  assign timeout_s  = in_edit_s && tick_1hz && (timer_q == TIMER_LAST) && !accepted_s;
  assign snap_s     = (state_q == ST_RUN) && btn_mode;

  // Session FSM next state: mode steps through the fields, idle timeout abandons.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          state_d = ST_EDIT_H;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EDIT_H: begin
        if (btn_mode) begin
          state_d = ST_EDIT_M;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_EDIT_H;
        end
      end
      ST_EDIT_M: begin
        if (btn_mode) begin
          state_d = ST_EDIT_S;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_EDIT_M;
        end
      end
      ST_EDIT_S: begin
        if (btn_mode) begin
          state_d = ST_COMMIT;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_EDIT_S;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Idle timer and blink phase: any accepted press restarts both.
  always_comb begin
    timer_d = timer_q;
    blink_d = blink_q;
    if (!in_edit_s || accepted_s || timeout_s) begin
      timer_d = {TMR_W{1'b0}};
      blink_d = 1'b1;
    end else begin
      if (tick_1hz) begin
        timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
      end else begin
        timer_d = timer_q;
      end
      if (tick_blink) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end
    end
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    run_en_d        = 1'b0;
    load_en_d       = 1'b0;
    edit_field_d    = EF_NONE;
    field_visible_d = 3'b111;
    case (state_d)
      ST_RUN:    run_en_d = 1'b1;
      ST_EDIT_H: begin
        edit_field_d    = EF_HOUR;
        field_visible_d = {blink_d, 2'b11};
      end
      ST_EDIT_M: begin
        edit_field_d    = EF_MIN;
        field_visible_d = {1'b1, blink_d, 1'b1};
      end
      ST_EDIT_S: begin
        edit_field_d    = EF_SEC;
        field_visible_d = {2'b11, blink_d};
      end
      ST_COMMIT: load_en_d = 1'b1;
      default:   run_en_d = 1'b1;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      timer_q         <= {TMR_W{1'b0}};
      blink_q         <= 1'b1;
      run_en_q        <= 1'b1;
      load_en_q       <= 1'b0;
      edit_field_q    <= EF_NONE;
      field_visible_q <= 3'b111;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      blink_q         <= blink_d;
      run_en_q        <= run_en_d;
      load_en_q       <= load_en_d;
      edit_field_q    <= edit_field_d;
      field_visible_q <= field_visible_d;
    end
  end

  // Mode wins over inc/dec, so a press that advances the field never edits.
  field_editor #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .snap_en_i(snap_s), .snap_val_i(cur_hour),
    .en_i(state_q == ST_EDIT_H), .inc_i(btn_inc && !btn_mode),
    .dec_i(btn_dec && !btn_mode), .value_o(hour_data)
  );

  field_editor #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .snap_en_i(snap_s), .snap_val_i(cur_min),
    .en_i(state_q == ST_EDIT_M), .inc_i(btn_inc && !btn_mode),
    .dec_i(btn_dec && !btn_mode), .value_o(min_data)
  );

  field_editor #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .snap_en_i(snap_s), .snap_val_i(cur_sec),
    .en_i(state_q == ST_EDIT_S), .inc_i(btn_inc && !btn_mode),
    .dec_i(btn_dec && !btn_mode), .value_o(sec_data)
  );

  assign run_en        = run_en_q;
  assign load_en       = load_en_q;
  assign edit_field    = edit_field_q;
  assign field_visible = field_visible_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: a session-level reference model
// predicts every cycle's outputs and every load; a monitor checks them.
module tb_clock_set_ctrl;

  localparam int HMAX = 23;
  localparam int MMAX = 59;
  localparam int SMAX = 59;
  localparam int TO   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic       tick_1hz = 1'b0, tick_blink = 1'b0;
  logic [5:0] cur_hour = 6'd0, cur_min = 6'd0, cur_sec = 6'd0;
  logic       run_en, load_en;
  logic [5:0] hour_data, min_data, sec_data;
  logic [1:0] edit_field;
  logic [2:0] field_visible;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOUR_MAX(HMAX), .MIN_MAX(MMAX), .SEC_MAX(SMAX), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .tick_1hz(tick_1hz), .tick_blink(tick_blink),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .load_en(load_en),
    .hour_data(hour_data), .min_data(min_data), .sec_data(sec_data),
    .edit_field(edit_field), .field_visible(field_visible)
  );

  typedef struct {
    int run_en; int load_en; int edit_field; int fv; int h; int m; int s;
  } exp_t;

  exp_t exp_q[$];
  int   load_q[$];
  int   checks = 0, failures = 0, load_cnt = 0, last_load = -1;

  // Reference model: mode 0 = running, 1..3 = editing hour/min/sec, 4 = commit.
  int md = 0, tmr = 0, blk = 1;
  int val[3] = '{0, 0, 0};
  int mx[3]  = '{HMAX, MMAX, SMAX};
  int nxt_h = 0, nxt_m = 0, nxt_s = 0;

  function automatic int pack(input int h, input int m, input int s);
    return (h << 12) | (m << 6) | s;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model(input bit m, input bit i, input bit d, input bit t1, input bit tb, input bit r);
    exp_t e;
    int f;
    if (r) begin
      md = 0; tmr = 0; blk = 1; val = '{0, 0, 0};
    end else if (md == 0) begin
      if (m) begin
        val = '{nxt_h, nxt_m, nxt_s};
        md = 1; tmr = 0; blk = 1;
      end
    end else if (md == 4) begin
      md = 0;
    end else begin
      f = md - 1;
      if (m) begin
        md = md + 1; tmr = 0; blk = 1;
      end else if (i != d) begin
        if (i) val[f] = (val[f] + 1) % (mx[f] + 1);
        else   val[f] = (val[f] + mx[f]) % (mx[f] + 1);
        tmr = 0; blk = 1;
      end else if (t1 && tmr == TO - 1) begin
        md = 0; tmr = 0; blk = 1;
      end else begin
        if (t1) tmr++;
        if (tb) blk = !blk;
      end
      if (md == 4) load_q.push_back(pack(val[0], val[1], val[2]));
    end
    e.run_en     = (md == 0) ? 1 : 0;
    e.load_en    = (md == 4) ? 1 : 0;
    e.edit_field = (md >= 1 && md <= 3) ? md : 0;
    e.fv         = (md >= 1 && md <= 3 && !blk) ? (7 & ~(1 << (3 - md))) : 7;
    e.h = val[0]; e.m = val[1]; e.s = val[2];
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus on the falling edge and record the prediction.
  task automatic step(input bit m, input bit i, input bit d, input bit t1, input bit tb, input bit r);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d; tick_1hz = t1; tick_blink = tb; rst = r;
    cur_hour = 6'(nxt_h); cur_min = 6'(nxt_m); cur_sec = 6'(nxt_s);
    model(m, i, d, t1, tb, r);
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    step(m, i, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered output shortly after each rising edge.
  initial begin
    exp_t e;
    int   p;
    forever begin
      @(posedge clk);
      #1;
      if (load_en === 1'b1) begin
        load_cnt++;
        last_load = pack(int'(hour_data), int'(min_data), int'(sec_data));
        if (load_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load: got load_en=1 expected none at %0t", $time);
        end else begin
          p = load_q.pop_front();
          chk("load_data", last_load, p);
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("run_en",        int'(run_en),        e.run_en);
        chk("load_en",       int'(load_en),       e.load_en);
        chk("edit_field",    int'(edit_field),    e.edit_field);
        chk("field_visible", int'(field_visible), e.fv);
        chk("hour_data",     int'(hour_data),     e.h);
        chk("min_data",      int'(min_data),      e.m);
        chk("sec_data",      int'(sec_data),      e.s);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bp;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle;
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_fv", int'(field_visible), 7);
    chk("rst_edit_field", int'(edit_field), 0);
    chk("rst_data", pack(int'(hour_data), int'(min_data), int'(sec_data)), 0);
    press(1'b0, 1'b0, 1'b0);

    // Full session 12:34:56 -> 15:33:56.
    nxt_h = 12; nxt_m = 34; nxt_s = 56;
    base = load_cnt;
    press(1'b1, 1'b0, 1'b0);
    settle;
    chk("enter_run_en", int'(run_en), 0);
    chk("snap_hour", int'(hour_data), 12);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    settle;
    chk("hour_inc3", int'(hour_data), 15);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    settle;
    chk("commit_load_en", int'(load_en), 1);
    chk("commit_run_en", int'(run_en), 0);
    press(1'b0, 1'b0, 1'b0);
    settle;
    chk("after_commit_run_en", int'(run_en), 1);
    chk("after_commit_load_en", int'(load_en), 0);
    chk("session_load_count", load_cnt - base, 1);
    chk("session_load_value", last_load, pack(15, 33, 56));

    // Wrap-around at the field limits.
    nxt_h = 23; nxt_m = 0; nxt_s = 59;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    settle;
    chk("hour_wrap", int'(hour_data), 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    settle;
    chk("min_wrap", int'(min_data), 59);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    settle;
    chk("sec_wrap", int'(sec_data), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous buttons, blink behaviour and reset during EDIT_M.
    nxt_h = 5; nxt_m = 10; nxt_s = 20;
    base = load_cnt;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    settle;
    chk("incdec_ignored", int'(hour_data), 5);
    press(1'b1, 1'b1, 1'b0);
    settle;
    chk("mode_inc_field", int'(edit_field), 2);
    chk("mode_inc_hour", int'(hour_data), 5);
    chk("mode_inc_min", int'(min_data), 10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle;
    chk("blink_off", int'(field_visible), 5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle;
    chk("blink_on", int'(field_visible), 7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle;
    chk("blink_off2", int'(field_visible), 5);
    press(1'b0, 1'b1, 1'b0);
    settle;
    chk("inc_forces_visible", int'(field_visible), 7);
    chk("min_inc", int'(min_data), 11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle;
    chk("rst_edit_run_en", int'(run_en), 1);
    chk("rst_edit_field", int'(edit_field), 0);
    chk("rst_edit_min", int'(min_data), 0);
    chk("rst_edit_no_load", load_cnt - base, 0);

    // Idle timeout abandons the session without a load.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nxt_h = 7; nxt_m = 8; nxt_s = 9;
    base = load_cnt;
    press(1'b1, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle;
    chk("pre_timeout_field", int'(edit_field), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle;
    chk("timeout_run_en", int'(run_en), 1);
    chk("timeout_field", int'(edit_field), 0);
    chk("timeout_no_load", load_cnt - base, 0);

    // Randomized traffic: busy blocks alternate with quiet ones that let timeouts happen.
    for (int blkn = 0; blkn < 20; blkn++) begin
      bp = (blkn % 2 == 0) ? 4 : 200;
      if (bp == 200) begin
        nxt_h = $urandom_range(HMAX, 0);
        press(1'b1, 1'b0, 1'b0);
      end
      for (int c = 0; c < 300; c++) begin
        nxt_h = $urandom_range(HMAX, 0);
        nxt_m = $urandom_range(MMAX, 0);
        nxt_s = $urandom_range(SMAX, 0);
        step($urandom_range(bp - 1, 0) == 0, $urandom_range(bp - 1, 0) == 0,
             $urandom_range(bp - 1, 0) == 0, $urandom_range(1, 0) == 0,
             $urandom_range(2, 0) == 0, $urandom_range(499, 0) == 0);
      end
    end

    press(1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0);
    settle;
    #3;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("load_queue_drained", load_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

User time-setting controller for the desk clock: the writer side of the seconds, minutes and hours counters' load interface. It converts debounced button pulses into an edit session over three fields: hour, then minute, then second. While a session is active it freezes timekeeping. On commit it drives a single load cycle into all three counters. It sits between the button debouncers and the counter chain, and also supplies field-blink information to the display mux.

## Interface
Parameters:
- HOUR_MAX, 23, hour field wrap limit (hours run 0..HOUR_MAX)
- MIN_MAX, 59, minute field wrap limit
- SEC_MAX, 59, second field wrap limit
- TIMEOUT_S, 30, idle seconds in edit before the session is abandoned (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_mode  in  1  one-cycle pulse; enter session / next field / commit
- btn_inc  in  1  one-cycle pulse; increment current field
- btn_dec  in  1  one-cycle pulse; decrement current field
- tick_1hz  in  1  one-cycle 1 Hz enable
- tick_blink  in  1  one-cycle blink-rate enable (nominally 2 Hz)
- cur_hour, cur_min, cur_sec  in  6 each  live counter values
- run_en  out  1  gate for the counter chain's count enable
- load_en  out  1  one-cycle load strobe to all three counters
- hour_data, min_data, sec_data  out  6 each  values to load; these are the live edit values
- edit_field  out  2  0 none, 1 hour, 2 min, 3 sec
- field_visible  out  3  {hour,min,sec}; a 0 blanks that display field

## Operation
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- RUN + btn_mode → EDIT_H.
  - Edit registers snapshot cur_* as sampled in the same cycle.
- EDIT_H + btn_mode → EDIT_M; EDIT_M + btn_mode → EDIT_S; EDIT_S + btn_mode → COMMIT.
- COMMIT → RUN unconditionally after one cycle.
- In an EDIT state:
  - btn_inc adds 1 to the current field; at its MAX the field wraps to 0.
  - btn_dec subtracts 1; at 0 the field wraps to its MAX.
  - btn_inc and btn_dec in the same cycle: both are ignored.
  - btn_mode together with inc or dec: mode wins and the inc/dec is dropped.
- Buttons have no effect in COMMIT. In RUN, inc and dec are ignored.
- Idle timer:
  - Cleared on session entry and on any accepted button pulse.
  - Counts tick_1hz while in an EDIT state.
  - tick_1hz when the timer equals TIMEOUT_S-1 → RUN next cycle, with no load; edits are discarded.
  - If a button pulse and the final tick land in the same cycle, the button is processed and the timer clears (no timeout).
- Blink:
  - blink_phase toggles on tick_blink in EDIT states.
  - It is set to 1 on field entry and on any inc/dec, so the value stays visible while adjusting.
  - field_visible is 1 for non-current fields and blink_phase for the current one.
  - In RUN and COMMIT, field_visible = 3'b111.
- Outputs:
  - run_en = 1 only in RUN.
  - load_en = 1 only in COMMIT.
  - edit_field follows the state (COMMIT reports 0).
- Arithmetic: 6-bit unsigned, no saturation.

## Timing
- All outputs are registered.
- Reset values:
  - State RUN, run_en 1, load_en 0.
  - hour_data, min_data, sec_data = 0.
  - edit_field 0, field_visible 3'b111, idle timer 0, blink_phase 1.
- btn_mode in RUN at cycle t:
  - EDIT_H and run_en = 0 from t+1.
  - The data outputs show the snapshot at t+1.
  - A counter increment coinciding with edge t is not reflected in the snapshot. This one-second loss is accepted.
- inc/dec at t → the updated value is visible at t+1.
- btn_mode in EDIT_S at t:
  - load_en = 1 during t+1 only.
  - RUN and run_en = 1 at t+2.
  - The counters show the loaded values at t+2.
- rst during any state returns to the reset values next cycle. No load is issued.

## Structure
- clock_pkg holds:
  - State encoding.
  - edit_field codes.
  - Field width (6).
  - Default limits 23/59/59.
- One sub-module, field_editor (parameter MAX), instantiated three times.
  - Holds one 6-bit value.
  - Handles snapshot load, wrap-around inc and dec, and an enable.
- The FSM, idle timer and blink logic live in the top.

## Test plan
- Reset → run_en=1, load_en=0, data outputs 0, field_visible=111, edit_field=0.
- cur=12:34:56, mode, 3×inc, mode, dec, mode, mode:
  - Exactly one load_en pulse, with hour_data=15, min_data=33, sec_data=56.
  - run_en returns at the cycle after the pulse.
- Wrap: hour snapshot 23, inc → 0. Min snapshot 0, dec → 59. Sec 59, inc → 0.
- Enter edit, then TIMEOUT_S tick_1hz pulses with no buttons → RUN, no load_en, run_en=1.
- Edge cases:
  - inc+dec in the same cycle → value unchanged.
  - mode+inc → field advances and the old field is unchanged.
  - rst asserted in EDIT_M → RUN next cycle, no load.
- Blink:
  - In EDIT_M, tick_blink toggles field_visible between 101 and 111.
  - inc forces 111 the next cycle.
